// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch FSM states, instruction
// field widths and the bubble/NOP encoding.
package cpu_pkg;

    localparam int OP_W    = 6;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_t;

    // Opcode field of an instruction word (top OP_W bits).
    function automatic logic [OP_W-1:0] op_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/ifetch_pc_next.sv
// pc_next: combinational next-PC selection for the fetch stage.
// Builds branch / jump / jr targets and picks the next PC by priority
// jr > jump > branch > stall hold > imem-wait hold > pc+4.
// Build option IFETCH_ALIGN_CHK_EN: force jr targets word-aligned and flag
// any jr whose target had non-zero low bits.
module pc_next #(
    parameter int n = 32
) (
    input  logic [n-1:0] pc_i,
    input  logic [n-1:0] pcplus4_id_i,
    input  logic [25:0]  jidx_i,
    input  logic [n-1:0] signimm_i,
    input  logic [n-1:0] jr_target_i,
    input  logic         valid_id_i,
    input  logic         jrsrc_i,
    input  logic         jump_i,
    input  logic         pcsrc_i,
    input  logic         stall_i,
    input  logic         imem_ready_i,
    output logic [n-1:0] pc_d_o,
    output logic [n-1:0] pc_plus4_o,
    output logic         redirect_o,
    output logic         jr_misalign_o
);

    logic [n-1:0] branch_tgt;
    logic [n-1:0] jump_tgt;
    logic [n-1:0] jr_tgt;

    assign pc_plus4_o = pc_i + n'(4);
    assign branch_tgt = pcplus4_id_i + (signimm_i << 2);
    assign jump_tgt   = {pcplus4_id_i[n-1:28], jidx_i, 2'b00};

`ifdef IFETCH_ALIGN_CHK_EN
    assign jr_tgt        = {jr_target_i[n-1:2], 2'b00};
    assign jr_misalign_o = valid_id_i & jrsrc_i & (jr_target_i[1:0] != 2'b00);
`else
    assign jr_tgt        = jr_target_i;
    assign jr_misalign_o = 1'b0;
`endif

    // A control-flow change is only real when the instruction in ID is real.
    assign redirect_o = valid_id_i & (jrsrc_i | jump_i | pcsrc_i);

    // Next-PC priority mux.
    always_comb begin
        pc_d_o = pc_plus4_o;
        if (valid_id_i && jrsrc_i) begin
            pc_d_o = jr_tgt;
        end else if (valid_id_i && jump_i) begin
            pc_d_o = jump_tgt;
        end else if (valid_id_i && pcsrc_i) begin
            pc_d_o = branch_tgt;
        end else if (stall_i || !imem_ready_i) begin
            pc_d_o = pc_i;
        end
    end

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction-fetch stage. Owns the PC, drives the imem address,
// holds the IF/ID register and counts imem wait cycles.
// Build option IFETCH_ALIGN_CHK_EN enables the sticky jr misalignment flag;
// without it misalign is tied low.
//
// state | meaning
// ------+------------------------------------------------
// FETCH | imem answering; a word is expected every cycle
// WAIT  | imem miss outstanding; PC held until imem_ready
module ifetch
    import cpu_pkg::*;
#(
    parameter int           n        = 32,
    parameter logic [n-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               pcsrc,
    input  logic               jump,
    input  logic               jrsrc,
    input  logic [n-1:0]       signimm,
    input  logic [n-1:0]       jr_target,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [n-1:0]       pc,
    output logic [INSTR_W-1:0] instr_id,
    output logic [n-1:0]       pcplus4_id,
    output logic               valid_id,
    output logic [OP_W-1:0]    op,
    output logic [15:0]        wait_cnt,
    output logic               misalign
);

    fetch_state_t       state_q, state_d;
    logic [n-1:0]       pc_q, pc_d;
    logic [n-1:0]       pc_plus4;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [n-1:0]       pcplus4_id_q, pcplus4_id_d;
    logic               valid_q, valid_d;
    logic [15:0]        wait_cnt_q, wait_cnt_d;
    logic               redirect;
    logic               jr_misalign;

    pc_next #(
        .n (n)
    ) u_pc_next (
        .pc_i          (pc_q),
        .pcplus4_id_i  (pcplus4_id_q),
        .jidx_i        (instr_q[25:0]),
        .signimm_i     (signimm),
        .jr_target_i   (jr_target),
        .valid_id_i    (valid_q),
        .jrsrc_i       (jrsrc),
        .jump_i        (jump),
        .pcsrc_i       (pcsrc),
        .stall_i       (stall),
        .imem_ready_i  (imem_ready),
        .pc_d_o        (pc_d),
        .pc_plus4_o    (pc_plus4),
        .redirect_o    (redirect),
        .jr_misalign_o (jr_misalign)
    );

    // IF/ID register next state: flush on redirect, hold on stall,
    // bubble on imem wait, otherwise capture the fetched word.
    always_comb begin
        instr_d      = instr_q;
        pcplus4_id_d = pcplus4_id_q;
        valid_d      = valid_q;
        if (redirect) begin
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (!imem_ready) begin
            valid_d = 1'b0;
        end else begin
            instr_d      = imem_rdata;
            pcplus4_id_d = pc_plus4;
            valid_d      = 1'b1;
        end
    end

    // Fetch FSM: tracks whether imem is answering; a redirect leaves it alone.
    always_comb begin
        state_d = state_q;
        if (!redirect) begin
            case (state_q)
                FETCH:   if (!imem_ready) state_d = WAIT;
                WAIT:    if (imem_ready)  state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // Wait-cycle counter, saturating rather than wrapping.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!imem_ready && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    // State, PC, IF/ID and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= NOP;
            pcplus4_id_q <= '0;
            valid_q      <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pcplus4_id_q <= pcplus4_id_d;
            valid_q      <= valid_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

`ifdef IFETCH_ALIGN_CHK_EN
    logic misalign_q;

    // Sticky misaligned-jr flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (jr_misalign) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign = misalign_q;
`else
    logic unused_jr_misalign;
    assign unused_jr_misalign = jr_misalign;
    assign misalign           = 1'b0;
`endif

    assign pc         = pc_q;
    assign instr_id   = instr_q;
    assign pcplus4_id = pcplus4_id_q;
    assign valid_id   = valid_q;
    assign op         = op_of(instr_q);
    assign wait_cnt   = wait_cnt_q;

endmodule
